// File: rtl/disp_pkg.sv
// Shared state encoding and constants for the display owner arbiter.
// Included by the arbiter top and its round-robin picker.
package disp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } disp_state_e;

    localparam logic [3:0] DOTS_OFF        = 4'b1111;
    localparam logic [3:0] HEX_RESET       = 4'h0;
    localparam int         HOLD_CYCLES_DEF = 50000000;

    // Advance a client index by step, wrapping at n (n <= 4).
    function automatic logic [1:0] rr_wrap(
        input logic [1:0] base,
        input logic [2:0] step,
        input logic [2:0] n
    );
        logic [2:0] s;
        s = {1'b0, base} + step;
        if (s >= n) begin
            s = s - n;
        end
        return s[1:0];
    endfunction

endpackage

// File: rtl/display_owner_arbiter_rr_pick.sv
// Round-robin picker: first requester after ptr_i, scanning upward with wrap.
// With excl_i set the client at ptr_i itself is never chosen.
module rr_priority_pick
    import disp_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [1:0]      ptr_i,
    input  logic            excl_i,
    output logic [NREQ-1:0] win_o,
    output logic [1:0]      idx_o,
    output logic            any_o
);

    logic [3:0] req4;
    logic [3:0] win4;
    logic [1:0] pos;

    assign req4 = 4'(req_i);

    always_comb begin
        win4  = '0;
        idx_o = '0;
        any_o = 1'b0;
        pos   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            pos = rr_wrap(ptr_i, k[2:0], 3'(NREQ));
            if (!any_o && req4[pos] && !(excl_i && k == NREQ)) begin
                any_o     = 1'b1;
                idx_o     = pos;
                win4[pos] = 1'b1;
            end
        end
    end

    assign win_o = win4[NREQ-1:0];

endmodule

// File: rtl/display_owner_arbiter.sv
// Round-robin owner arbiter for the shared 4-digit 7-segment display.
// Define DISP_OWNER_DOT_EN to light only the owner's decimal point.
module display_owner_arbiter
    import disp_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int HOLD_W      = 26
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   value,
    input  logic [4*NREQ-1:0]    dots,
    output logic [NREQ-1:0]      grant,
    output logic                 owner_valid,
    output logic [1:0]           owner_id,
    output logic [3:0]           hexa3,
    output logic [3:0]           hexa2,
    output logic [3:0]           hexa1,
    output logic [3:0]           hexa0,
    output logic [3:0]           puntos4
);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [1:0]        PTR_RST  = 2'(NREQ - 1);

    if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
        $error("NREQ must be in 2..4");
    end
    if ((64'd1 << HOLD_W) <= 64'(HOLD_CYCLES)) begin : g_bad_hold
        $error("HOLD_W too narrow for HOLD_CYCLES");
    end

    disp_state_e       state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [1:0]        id_q, id_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [15:0]       hex_q, hex_d;
    logic [3:0]        dots_q, dots_d;

    logic [3:0]        req4;
    logic [63:0]       value_all;
    logic [15:0]       dots_all;
    logic              own_req;
    logic              expired;
    logic [15:0]       own_val;
    logic [3:0]        own_dots;
    logic [NREQ-1:0]   pick_win;
    logic [1:0]        pick_idx;
    logic              pick_any;

    assign req4      = 4'(req);
    assign value_all = 64'(value);
    assign dots_all  = 16'(dots);
    assign own_req   = req4[id_q];
    assign expired   = (cnt_q == HOLD_MAX);
    assign own_val   = value_all[{id_q, 4'b0000} +: 16];

`ifdef DISP_OWNER_DOT_EN
    assign own_dots  = ~(4'b0001 << id_q);
`else
    assign own_dots  = dots_all[{id_q, 2'b00} +: 4];
`endif

    // In SHOW the pointer equals the owner, so excluding it skips the owner.
    rr_priority_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req_i  (req),
        .ptr_i  (ptr_q),
        .excl_i (state_q == SHOW),
        .win_o  (pick_win),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        hex_d   = hex_q;
        dots_d  = dots_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = SHOW;
                    grant_d = pick_win;
                    id_d    = pick_idx;
                    ptr_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            SHOW: begin
                hex_d  = own_val;
                dots_d = own_dots;
                if (!own_req && !pick_any) begin
                    state_d = IDLE;
                    grant_d = '0;
                    hex_d   = hex_q;
                    dots_d  = DOTS_OFF;
                end else if (!own_req || (expired && pick_any)) begin
                    grant_d = pick_win;
                    id_d    = pick_idx;
                    ptr_d   = pick_idx;
                    cnt_d   = '0;
                end else if (!expired) begin
                    cnt_d = cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            id_q    <= '0;
            ptr_q   <= PTR_RST;
            cnt_q   <= '0;
            hex_q   <= {4{HEX_RESET}};
            dots_q  <= DOTS_OFF;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            hex_q   <= hex_d;
            dots_q  <= dots_d;
        end
    end

    assign grant       = grant_q;
    assign owner_valid = (state_q == SHOW);
    assign owner_id    = id_q;
    assign hexa3       = hex_q[15:12];
    assign hexa2       = hex_q[11:8];
    assign hexa1       = hex_q[7:4];
    assign hexa0       = hex_q[3:0];
    assign puntos4     = dots_q;

endmodule

// File: tb/tb_display_owner_arbiter.sv
// Scoreboard bench for display_owner_arbiter.
// NREQ=4, HOLD_CYCLES=8.
module tb_display_owner_arbiter;

  typedef struct {
    int          at;
    string       tag;
    logic [3:0]  g;
    logic        v;
    logic [1:0]  id;
    bit          cid;
    logic [15:0] hx;
    bit          chx;
    logic [3:0]  pt;
    bit          cpt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] value;
  logic [15:0] dots;
  logic [3:0]  grant;
  logic        owner_valid;
  logic [1:0]  owner_id;
  logic [3:0]  hexa3, hexa2, hexa1, hexa0;
  logic [3:0]  puntos4;

  logic [15:0] vtab [4];
  logic [3:0]  dtab [4];
  exp_t        sb [$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  display_owner_arbiter #(
    .NREQ        (4),
    .HOLD_CYCLES (8),
    .HOLD_W      (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .value       (value),
    .dots        (dots),
    .grant       (grant),
    .owner_valid (owner_valid),
    .owner_id    (owner_id),
    .hexa3       (hexa3),
    .hexa2       (hexa2),
    .hexa1       (hexa1),
    .hexa0       (hexa0),
    .puntos4     (puntos4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] xd(input int i);
`ifdef DISP_OWNER_DOT_EN
    return ~(4'b0001 << i);
`else
    return dtab[i];
`endif
  endfunction

  task automatic apply();
    value = {vtab[3], vtab[2], vtab[1], vtab[0]};
    dots  = {dtab[3], dtab[2], dtab[1], dtab[0]};
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int at, input string tag,
                      input logic [3:0] g, input logic v,
                      input logic [1:0] id, input bit cid,
                      input logic [15:0] hx, input bit chx,
                      input logic [3:0] pt, input bit cpt);
    exp_t e;
    e.at = at; e.tag = tag; e.g = g; e.v = v;
    e.id = id; e.cid = cid; e.hx = hx; e.chx = chx;
    e.pt = pt; e.cpt = cpt;
    sb.push_back(e);
  endtask

  task automatic pg(input int at, input string tag,
                    input logic [3:0] g, input logic [1:0] id);
    push(at, tag, g, 1'b1, id, 1'b1, 16'h0, 1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    exp_t e;
    logic [15:0] hx;
    bit ok;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e  = sb.pop_front();
        hx = {hexa3, hexa2, hexa1, hexa0};
        total++;
        ok = (grant === e.g) && (owner_valid === e.v)
          && (!e.cid || owner_id === e.id)
          && (!e.chx || hx === e.hx)
          && (!e.cpt || puntos4 === e.pt)
          && (e.at == cyc);
        if (!ok) begin
          bad++;
          $display("FAIL %s cyc=%0d/%0d got g=%b v=%b id=%0d hex=%h pt=%b want g=%b v=%b id=%0d hex=%h pt=%b",
                   e.tag, cyc, e.at, grant, owner_valid, owner_id,
                   hx, puntos4, e.g, e.v, e.id, e.hx, e.pt);
        end
      end
    end
  end

  initial begin
    vtab = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    dtab = '{4'b1010, 4'b0101, 4'b0000, 4'b0011};
    apply();
    reset = 1'b1;
    req   = 4'b0101;

    tick(2);
    total++;
    if (grant !== 4'b0000 || puntos4 !== 4'b1111) begin
      bad++;
      $display("FAIL in_reset g=%b pt=%b", grant, puntos4);
    end
    push(2, "reset_state", 4'b0000, 1'b0, 2'd0, 1'b1,
         16'h0000, 1'b1, 4'b1111, 1'b1);
    reset = 1'b0;
    push(3, "first_grant", 4'b0001, 1'b1, 2'd0, 1'b1,
         16'h0000, 1'b1, 4'b1111, 1'b1);
    push(4, "first_data", 4'b0001, 1'b1, 2'd0, 1'b1,
         16'h1234, 1'b1, xd(0), 1'b1);

    tick(2);
    req = 4'b1111;
    pg(10, "hold0_end", 4'b0001, 2'd0);
    pg(11, "rot_to_1", 4'b0010, 2'd1);
    push(12, "data_1", 4'b0010, 1'b1, 2'd1, 1'b1,
         16'h5678, 1'b1, xd(1), 1'b1);
    pg(18, "hold1_end", 4'b0010, 2'd1);
    pg(19, "rot_to_2", 4'b0100, 2'd2);
    pg(26, "hold2_end", 4'b0100, 2'd2);
    pg(27, "rot_to_3", 4'b1000, 2'd3);
    pg(34, "hold3_end", 4'b1000, 2'd3);
    pg(35, "rot_to_0", 4'b0001, 2'd0);

    tick(31);
    total++;
    if (grant !== 4'b0001) begin
      bad++;
      $display("FAIL wrap_grant g=%b", grant);
    end
    req = 4'b0100;
    pg(36, "drop_switch", 4'b0100, 2'd2);
    push(37, "owner2_dots", 4'b0100, 1'b1, 2'd2, 1'b1,
         16'h9ABC, 1'b1, xd(2), 1'b1);
    push(39, "owner2_hold3", 4'b0100, 1'b1, 2'd2, 1'b1,
         16'h9ABC, 1'b1, xd(2), 1'b1);

    tick(4);
    req = 4'b0000;
    push(40, "release_idle", 4'b0000, 1'b0, 2'd2, 1'b1,
         16'h9ABC, 1'b1, 4'b1111, 1'b1);

    tick(2);
    push(41, "stay_idle", 4'b0000, 1'b0, 2'd2, 1'b1,
         16'h9ABC, 1'b1, 4'b1111, 1'b1);
    req = 4'b0010;
    pg(42, "sole_grant", 4'b0010, 2'd1);
    push(43, "sole_data", 4'b0010, 1'b1, 2'd1, 1'b1,
         16'h5678, 1'b1, xd(1), 1'b1);
    pg(50, "sole_sat", 4'b0010, 2'd1);
    pg(61, "sole_hold20", 4'b0010, 2'd1);

    tick(20);
    total++;
    if (grant !== 4'b0010) begin
      bad++;
      $display("FAIL sole_direct g=%b", grant);
    end
    req = 4'b1010;
    pg(62, "late_req3", 4'b1000, 2'd3);
    push(63, "data_3", 4'b1000, 1'b1, 2'd3, 1'b1,
         16'hDEF0, 1'b1, xd(3), 1'b1);

    tick(2);
    vtab[3] = 16'h1234;
    apply();
    push(64, "live_1234", 4'b1000, 1'b1, 2'd3, 1'b1,
         16'h1234, 1'b1, xd(3), 1'b1);

    tick(1);
    vtab[3] = 16'hABCD;
    apply();
    push(65, "live_abcd", 4'b1000, 1'b1, 2'd3, 1'b1,
         16'hABCD, 1'b1, xd(3), 1'b1);

    tick(2);
    reset = 1'b1;
    #1;
    total++;
    if (grant !== 4'b0000 || owner_valid !== 1'b0) begin
      bad++;
      $display("FAIL async_direct g=%b v=%b", grant, owner_valid);
    end
    push(66, "async_reset", 4'b0000, 1'b0, 2'd0, 1'b1,
         16'h0000, 1'b1, 4'b1111, 1'b1);
    push(67, "reset_held", 4'b0000, 1'b0, 2'd0, 1'b1,
         16'h0000, 1'b1, 4'b1111, 1'b1);

    tick(2);
    reset = 1'b0;
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      @(negedge clk);
    end
    #1;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL %s never checked: due cyc=%0d now cyc=%0d",
               e.tag, e.at, cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_owner_arbiter.md
Name: display_owner_arbiter

Overview:
- Shares the single 4-digit multiplexed 7-segment display between NREQ client blocks, e.g. counter, UART monitor and debug registers.
- Round-robin arbitration with a minimum hold time per owner, so each value stays readable.
- Drives the hexa3..hexa0 and puntos4 inputs of the display multiplexer from registers.
- Returns a one-hot grant to each client.

Parameters:
- NREQ, 4, number of requesting clients (2..4).
- HOLD_CYCLES, 50000000, minimum clk cycles an owner keeps the display while others wait (1 s at 50 MHz).
- HOLD_W, 26, width of the hold counter; must satisfy 2^HOLD_W > HOLD_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- req  in  NREQ  per-client display request, level-sensitive
- value  in  16*NREQ  client i digits at [16i+15:16i]; nibble 3 = leftmost digit
- dots  in  4*NREQ  client i decimal points at [4i+3:4i]; active-low, as fed to the display
- grant  out  NREQ  one-hot current owner; all zero when idle
- owner_valid  out  1  high while in SHOW
- owner_id  out  2  index of current owner; holds last owner when idle
- hexa3, hexa2, hexa1, hexa0  out  4 each  digit nibbles to the display mux
- puntos4  out  4  decimal points to the display mux

Behaviour:
- Reset values: state=IDLE, grant=0, owner_valid=0, owner_id=0, hexa*=4'h0, puntos4=4'b1111 (all points off), hold counter=0, rr pointer=NREQ-1 (client 0 wins first).
- States: IDLE (no owner) and SHOW (one owner).
- IDLE -> SHOW:
  - Triggered when any req is high.
  - Winner is the first requester after the rr pointer, scanning upward with wrap.
  - grant, owner_id and owner_valid register on the same edge; counter clears to 0.
- SHOW, data path:
  - hexa*/puntos4 register the owner's live value/dots every cycle.
  - Latency is exactly 1 cycle from a value change to the outputs.
  - The first owner data appears 1 cycle after grant rises.
- SHOW, hold counter:
  - Increments each cycle and saturates at HOLD_CYCLES-1.
  - "expired" = counter == HOLD_CYCLES-1.
- SHOW, owner drops req, evaluated every cycle:
  - If any other req is high, switch immediately to the next round-robin winner and clear the counter.
  - Otherwise go to IDLE with grant=0.
  - hexa* keep their last value; puntos4 goes to 4'b1111.
- SHOW, owner still requesting:
  - Expired and another requester pending: switch to the next round-robin winner (the owner is excluded) and clear the counter.
  - Expired with no other requester: keep the owner, and the counter stays saturated.
  - Not expired: keep the owner, regardless of other requests.
- Pointer: the rr pointer updates to the new owner on every grant.
- Grant: never more than one bit high; it changes only on clk edges.
- Simultaneous requests: the round-robin order decides; there is no fixed priority.
- Reset mid-SHOW: immediate return to reset values. A grant deasserts asynchronously.
- Out-of-range clients: req bits at index >= NREQ do not exist; owner_id never exceeds NREQ-1.

Optional Feature:
- Macro DISP_OWNER_DOT_EN.
- When defined:
  - In SHOW, puntos4 ignores client dots and shows the owner index.
  - Only point owner_id is lit: puntos4 = ~(4'b0001 << owner_id).
  - In IDLE, puntos4 = 4'b1111.
- When undefined: client dots pass through as described in Behaviour.

Decomposition:
- Package disp_pkg holds:
  - the state encoding (IDLE=1'b0, SHOW=1'b1);
  - DOTS_OFF = 4'b1111;
  - HEX_RESET = 4'h0;
  - the default HOLD_CYCLES.
- One combinational sub-module, rr_priority_pick.
  - Inputs: req vector, pointer, exclude-owner flag.
  - Outputs: one-hot winner and winner index, plus any_valid.
  - Used for both the IDLE and SHOW decisions.

Test Plan (HOLD_CYCLES=8, NREQ=4):
- Reset with req=4'b0101 held, then release reset:
  - 1 cycle later: grant=4'b0001, owner_id=0.
  - Next cycle: hexa3..0 = value[15:0] nibbles.
- Rotation:
  - Client 0 owns; req=4'b1111 constant.
  - Grants rotate 0 -> 1 -> 2 -> 3 -> 0, each held exactly 8 cycles.
- Voluntary release with no other request:
  - Client 2 owns, others idle; drop req[2] at cycle 3 of hold.
  - Next edge: grant=0, owner_valid=0, puntos4=4'b1111, hexa* unchanged.
- Sole requester:
  - Client 1 alone requests for 20 cycles.
  - grant=4'b0010 stays constant.
  - Raise req[3] at cycle 20: grant=4'b1000 on the next edge.
- Live update:
  - Owner value changes 16'h1234 -> 16'hABCD.
  - hexa3..0 = A,B,C,D exactly 1 cycle later.
- Macro DISP_OWNER_DOT_EN:
  - Owner_id=2 with dots=4'b0000 gives puntos4=4'b1011.
  - Asserting reset mid-SHOW forces grant=0 with no clock edge.
